// File: rtl/sad_search_ctrl.sv
// SAD motion-search sequencer: issues candidate block addresses in raster
// order, accepts in-order SAD results and keeps the running minimum.
module sad_search_ctrl #(
   parameter int FRAME_W = 64,
   parameter int FRAME_H = 64,
   parameter int BLK     = 4,
   parameter int ADDR_W  = 12,
   parameter int SAD_W   = 12,
   parameter int MAX_OUT = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              hold_i,
   output logic              cand_valid_o,
   output logic [ADDR_W-1:0] cand_addr_o,
   output logic [7:0]        cand_x_o,
   output logic [7:0]        cand_y_o,
   input  logic              sad_valid_i,
   input  logic [SAD_W-1:0]  sad_in_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [SAD_W-1:0]  best_sad_o,
   output logic [7:0]        best_x_o,
   output logic [7:0]        best_y_o,
   output logic              error_o
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);
   localparam logic [7:0]    X_LAST  = 8'(FRAME_W - BLK);
   localparam logic [7:0]    Y_LAST  = 8'(FRAME_H - BLK);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

   state_e              state_q;
   logic [7:0]          ix_q, iy_q, rx_q, ry_q;
   logic [OW-1:0]       outst_q, outst_d;
   logic                cand_valid_q, busy_q, done_q, error_q;
   logic [ADDR_W-1:0]   cand_addr_q;
   logic [7:0]          cand_x_q, cand_y_q, best_x_q, best_y_q;
   logic [SAD_W-1:0]    best_sad_q;

   logic                busy_st, issue, accept, spurious, last_issue;
   logic [31:0]         addr_full;

   // Issue/accept qualifiers; occupancy is judged on the count before this cycle.
   always_comb begin
      busy_st    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      issue      = (state_q == S_ISSUE) && !hold_i && (outst_q < OUT_MAX);
      accept     = busy_st && sad_valid_i && (outst_q != '0);
      spurious   = busy_st && sad_valid_i && (outst_q == '0);
      last_issue = issue && (ix_q == X_LAST) && (iy_q == Y_LAST);
      addr_full  = 32'(iy_q) * 32'(FRAME_W) + 32'(ix_q);
   end

   // Outstanding count: simultaneous issue and accept cancel out.
   always_comb begin
      outst_d = outst_q;
      if (issue && !accept)
         outst_d = outst_q + OW'(1);
      else if (accept && !issue)
         outst_d = outst_q - OW'(1);
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         ix_q         <= '0;
         iy_q         <= '0;
         rx_q         <= '0;
         ry_q         <= '0;
         outst_q      <= '0;
         cand_valid_q <= 1'b0;
         cand_addr_q  <= '0;
         cand_x_q     <= '0;
         cand_y_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         best_sad_q   <= '1;
         best_x_q     <= '0;
         best_y_q     <= '0;
      end else begin
         cand_valid_q <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q    <= S_ISSUE;
                  busy_q     <= 1'b1;
                  ix_q       <= '0;
                  iy_q       <= '0;
                  rx_q       <= '0;
                  ry_q       <= '0;
                  outst_q    <= '0;
                  best_sad_q <= '1;
                  best_x_q   <= '0;
                  best_y_q   <= '0;
                  error_q    <= 1'b0;
               end
            end
            S_ISSUE, S_DRAIN: begin
               outst_q <= outst_d;
               if (issue) begin
                  cand_valid_q <= 1'b1;
                  cand_x_q     <= ix_q;
                  cand_y_q     <= iy_q;
                  cand_addr_q  <= addr_full[ADDR_W-1:0];
                  if (ix_q == X_LAST) begin
                     ix_q <= '0;
                     iy_q <= iy_q + 8'd1;
                  end else begin
                     ix_q <= ix_q + 8'd1;
                  end
               end
               if (accept) begin
                  // strict compare: ties keep the earlier raster position
                  if (sad_in_i < best_sad_q) begin
                     best_sad_q <= sad_in_i;
                     best_x_q   <= rx_q;
                     best_y_q   <= ry_q;
                  end
                  if (rx_q == X_LAST) begin
                     rx_q <= '0;
                     ry_q <= ry_q + 8'd1;
                  end else begin
                     rx_q <= rx_q + 8'd1;
                  end
               end
               if (spurious)
                  error_q <= 1'b1;
               if ((state_q == S_ISSUE) && last_issue) begin
                  state_q <= S_DRAIN;
               end else if ((state_q == S_DRAIN) && (outst_d == '0)) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cand_valid_o = cand_valid_q;
   assign cand_addr_o  = cand_addr_q;
   assign cand_x_o     = cand_x_q;
   assign cand_y_o     = cand_y_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign best_sad_o   = best_sad_q;
   assign best_x_o     = best_x_q;
   assign best_y_o     = best_y_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl on an 8x8 frame with 4x4 blocks, with a
// fixed-latency datapath model and a raster-order reference.
module tb_sad_search_ctrl;
   localparam int FW = 8, FH = 8, BK = 4, AW = 12, SW = 12, MO = 8;
   localparam int NX = FW - BK + 1, NY = FH - BK + 1, N = NX * NY;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0, sad_valid = 1'b0;
   logic [SW-1:0] sad_in = '0;
   logic          cand_valid_o, busy_o, done_o, error_o;
   logic [AW-1:0] cand_addr_o;
   logic [7:0]    cand_x_o, cand_y_o, best_x_o, best_y_o;
   logic [SW-1:0] best_sad_o;

   sad_search_ctrl #(.FRAME_W(FW), .FRAME_H(FH), .BLK(BK), .ADDR_W(AW),
                     .SAD_W(SW), .MAX_OUT(MO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .hold_i(hold),
      .cand_valid_o(cand_valid_o), .cand_addr_o(cand_addr_o),
      .cand_x_o(cand_x_o), .cand_y_o(cand_y_o),
      .sad_valid_i(sad_valid), .sad_in_i(sad_in),
      .busy_o(busy_o), .done_o(done_o), .best_sad_o(best_sad_o),
      .best_x_o(best_x_o), .best_y_o(best_y_o), .error_o(error_o));

   always #5 clk = ~clk;

   typedef struct {int x; int y; int a;} cand_t;
   typedef struct {int due; int sad;} ret_t;

   int    n_checks = 0, n_err = 0;
   int    sad_map[NX][NY];
   cand_t eq[$];
   ret_t  dq[$];
   int    exp_best, exp_bx, exp_by;
   int    max_out, first_iss, last_iss, hold_viol, mark_n, mark_edge;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: raster list of candidates and strict-minimum search.
   task automatic ref_setup();
      eq.delete();
      exp_best = (1 << SW) - 1; exp_bx = 0; exp_by = 0;
      for (int y = 0; y < NY; y++)
         for (int x = 0; x < NX; x++) begin
            eq.push_back('{x, y, y * FW + x});
            if (sad_map[x][y] < exp_best) begin
               exp_best = sad_map[x][y]; exp_bx = x; exp_by = y;
            end
         end
   endtask

   task automatic fill_map(input int base);
      for (int y = 0; y < NY; y++)
         for (int x = 0; x < NX; x++) sad_map[x][y] = base;
   endtask

   task automatic fill_rand();
      for (int y = 0; y < NY; y++)
         for (int x = 0; x < NX; x++) sad_map[x][y] = int'($urandom_range(1, 4000));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cvalid"}, 32'(cand_valid_o), 0);
      check({tag, "_caddr"},  32'(cand_addr_o), 0);
      check({tag, "_cx"},     32'(cand_x_o), 0);
      check({tag, "_cy"},     32'(cand_y_o), 0);
      check({tag, "_busy"},   32'(busy_o), 0);
      check({tag, "_done"},   32'(done_o), 0);
      check({tag, "_error"},  32'(error_o), 0);
      check({tag, "_bsad"},   32'(best_sad_o), 32'hFFF);
      check({tag, "_bx"},     32'(best_x_o), 0);
      check({tag, "_by"},     32'(best_y_o), 0);
   endtask

   // One search: edge index c counts clock edges after the Start edge.
   task automatic run_search(input int lat, input int h0, input int h1, input int start_at,
                             input bit spur, input int rst_at, output bit aborted);
      int c, issued, returned, exp_done, outst;
      bit hold_now;
      cand_t e;
      c = 0; issued = 0; returned = 0; exp_done = -1;
      ref_setup(); dq.delete();
      max_out = 0; first_iss = -1; last_iss = -1; hold_viol = 0; mark_edge = -1;
      aborted = 1'b0;
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      check("busy_after_start", 32'(busy_o), 1);
      while (c < 600) begin
         hold_now  = (c + 1 >= h0) && (c + 1 <= h1);
         hold      = hold_now;
         start     = (c + 1 == start_at);
         sad_valid = 1'b0; sad_in = '0;
         if (spur && c + 1 == 1) begin
            sad_valid = 1'b1; sad_in = '0;
         end else if (dq.size() > 0 && dq[0].due == c + 1) begin
            sad_valid = 1'b1; sad_in = SW'(dq[0].sad);
            void'(dq.pop_front());
            returned++;
            if (returned == N) exp_done = c + 1;
         end
         @(posedge clk); #1; c++;
         hold = 1'b0; start = 1'b0; sad_valid = 1'b0;
         if (cand_valid_o) begin
            if (hold_now) hold_viol++;
            if (eq.size() == 0) begin
               check("extra_cand", 32'(cand_valid_o), 0);
            end else begin
               e = eq.pop_front();
               check("cand_addr", 32'(cand_addr_o), e.a);
               check("cand_x", 32'(cand_x_o), e.x);
               check("cand_y", 32'(cand_y_o), e.y);
               dq.push_back('{c + lat, sad_map[e.x][e.y]});
            end
            issued++;
            if (first_iss < 0) first_iss = c;
            last_iss = c;
            if (issued == mark_n) mark_edge = c;
         end
         outst = issued - returned;
         if (outst > max_out) max_out = outst;
         if (rst_at > 0 && issued == rst_at) begin
            aborted = 1'b1;
            return;
         end
         if (done_o) break;
      end
      check("done_seen", 32'(done_o), 1);
      check("done_timing", c, exp_done);
      check("issued_count", issued, N);
      check("busy_in_done", 32'(busy_o), 0);
      check("best_sad", 32'(best_sad_o), exp_best);
      check("best_x", 32'(best_x_o), exp_bx);
      check("best_y", 32'(best_y_o), exp_by);
      check("error_flag", 32'(error_o), 32'(spur));
   endtask

   task automatic post_done(input bit pulse_start);
      start = pulse_start; @(posedge clk); #1; start = 1'b0;
      check("done_one_cycle", 32'(done_o), 0);
      check("idle_after_done", 32'(busy_o), 0);
      @(posedge clk); #1;
      check("no_restart", 32'(busy_o), 0);
      check("best_holds", 32'(best_sad_o), exp_best);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ab;
      mark_n = 0;
      // reset state
      repeat (2) @(posedge clk);
      #1 check_reset_vals("rst");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // single minimum, latency 3, no hold
      fill_map(100); sad_map[2][3] = 7;
      run_search(3, 0, -1, -1, 1'b0, -1, ab);
      check("consecutive_issue", last_iss - first_iss, N - 1);
      check("max_outstanding_l3", max_out, 3);
      post_done(1'b0);

      // tie keeps the earlier position; Start during ISSUE and during DONE
      fill_map(9); sad_map[1][0] = 5; sad_map[3][4] = 5;
      run_search(3, 0, -1, 3, 1'b0, -1, ab);
      post_done(1'b1);

      // latency 12 saturates the pipeline: 9th issue waits for first result
      fill_rand();
      mark_n = 9;
      run_search(12, 0, -1, -1, 1'b0, -1, ab);
      check("max_outstanding_l12", max_out, MO);
      check("ninth_issue_edge", mark_edge, 1 + 12 + 1);
      post_done(1'b0);

      // Hold for ISSUE cycles 5..9: issue resumes at the 5th position
      fill_map(100); sad_map[2][3] = 7;
      mark_n = 5;
      run_search(3, 5, 9, -1, 1'b0, -1, ab);
      check("hold_blocks_issue", hold_viol, 0);
      check("fifth_issue_edge", mark_edge, 10);
      post_done(1'b0);
      mark_n = 0;

      // spurious SadValid with nothing outstanding: flagged, dropped
      fill_rand();
      run_search(4, 0, -1, -1, 1'b1, -1, ab);
      post_done(1'b0);

      // reset in the middle of ISSUE, then a full clean search
      fill_rand();
      run_search(3, 0, -1, -1, 1'b0, 10, ab);
      check("reset_abort_reached", 32'(ab), 1);
      #1 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      dq.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      fill_map(100); sad_map[4][4] = 3; sad_map[0][1] = 50;
      run_search(3, 0, -1, -1, 1'b0, -1, ab);
      post_done(1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
